// File: rtl/reg_bank_pkg.sv
// Shared types and the next-value rule for the reg_bank register file.
// next_val works on a fixed 64-bit container so a single function serves
// every WIDTH from 2 up to MAX_W; callers zero-extend their operands and
// keep the low WIDTH bits of the result.
package reg_bank_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_CLRR = 3'b110,
        OP_ADD  = 3'b111
    } op_e;

    typedef logic [MAX_W-1:0] word_t;

    // co sits above val so the low MAX_W bits of the packed struct are the value
    typedef struct packed {
        logic  co;
        word_t val;
    } nv_t;

    // Computes the new register contents and carry/borrow/shift-out for one
    // operation on a w-bit register. cur and d must already be zero above bit w-1.
    function automatic nv_t next_val(input op_e op, input word_t cur, input word_t d,
                                     input int unsigned w);
        word_t          mask;
        word_t          msbBit;
        logic [MAX_W:0] sum;
        nv_t            res;
        mask   = (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
        msbBit = word_t'(1) << (w - 1);
        sum    = {1'b0, cur} + {1'b0, d};
        res.co  = 1'b0;
        res.val = cur;
        case (op)
            OP_HOLD: begin
                res.val = cur;
            end
            OP_LOAD: begin
                res.val = d & mask;
            end
            OP_INC: begin
                res.val = (cur + word_t'(1)) & mask;
                res.co  = (cur == mask);
            end
            OP_DEC: begin
                res.val = (cur - word_t'(1)) & mask;
                res.co  = (cur == '0);
            end
            OP_SHL: begin
                res.val = ((cur << 1) | (d & word_t'(1))) & mask;
                res.co  = |(cur & msbBit);
            end
            OP_SHR: begin
                res.val = ((|(d & msbBit)) ? msbBit : '0) | (cur >> 1);
                res.co  = cur[0];
            end
            OP_CLRR: begin
                res.val = '0;
            end
            OP_ADD: begin
                res.val = sum[MAX_W-1:0] & mask;
                res.co  = |(sum & ((MAX_W+1)'(1) << w));
            end
            default: begin
                res.val = cur;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational operate unit for the register currently addressed by WSEL.
// Produces the candidate next value and carry, plus a flag saying whether
// the operation changes state at all (HOLD leaves both register and CO alone).
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_val,
    output logic             o_co,
    output logic             o_change
);

    // Evaluate the shared next-value rule; the value lives in the low bits and co above it
    always_comb begin
        o_val    = WIDTH'(next_val(i_op, word_t'(i_cur), word_t'(i_d), WIDTH));
        o_co     = 1'(next_val(i_op, word_t'(i_cur), word_t'(i_d), WIDTH) >> MAX_W);
        o_change = (i_op != OP_HOLD);
    end

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file with one operate port and two gated
// read ports feeding the ALU operand buses.
// Optional feature: define REG_BANK_BYPASS_EN to forward the value being
// written this cycle onto Q/Qa/Qb ahead of the clock edge.
// Selects at or above DEPTH address nothing: writes are dropped and reads give 0.
// WIDTH must lie between 2 and reg_bank_pkg::MAX_W.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int   WIDTH = 16,
    parameter int   DEPTH = 8,
    localparam int  AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             R_W,
    input  logic [2:0]       OP,
    input  logic [AW-1:0]    WSEL,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    ASEL,
    input  logic [AW-1:0]    BSEL,
    input  logic             Ea,
    input  logic             Eb,
    output logic [WIDTH-1:0] Qa,
    output logic [WIDTH-1:0] Qb,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             Z
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_co;

    logic [WIDTH-1:0] w_curVal;
    logic [WIDTH-1:0] w_aStored;
    logic [WIDTH-1:0] w_bStored;
    logic             w_wselOk;
    logic [WIDTH-1:0] w_nextVal;
    logic             w_nextCo;
    logic             w_change;
    logic             w_write;
    logic [WIDTH-1:0] w_qView;
    logic [WIDTH-1:0] w_aView;
    logic [WIDTH-1:0] w_bView;

    // Decode the three selects against the populated registers; unmatched selects read 0
    always_comb begin
        w_curVal  = '0;
        w_aStored = '0;
        w_bStored = '0;
        w_wselOk  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (WSEL == AW'(i)) begin
                w_curVal = r_regs[i];
                w_wselOk = 1'b1;
            end
            if (ASEL == AW'(i)) begin
                w_aStored = r_regs[i];
            end
            if (BSEL == AW'(i)) begin
                w_bStored = r_regs[i];
            end
        end
    end

    reg_bank_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_op     (op_e'(OP)),
        .i_cur    (w_curVal),
        .i_d      (D),
        .o_val    (w_nextVal),
        .o_co     (w_nextCo),
        .o_change (w_change)
    );

    // A state change happens only for a real operation on an existing register outside reset
    assign w_write = !CLR && !R_W && w_change && w_wselOk;

`ifdef REG_BANK_BYPASS_EN
    // Forward the pending write so the ALU sees the new operand in the same cycle
    assign w_qView = w_write ? w_nextVal : w_curVal;
    assign w_aView = (w_write && (ASEL == WSEL)) ? w_nextVal : w_aStored;
    assign w_bView = (w_write && (BSEL == WSEL)) ? w_nextVal : w_bStored;
`else
    // Reads always reflect stored contents; writes become visible after the edge
    assign w_qView = w_curVal;
    assign w_aView = w_aStored;
    assign w_bView = w_bStored;
`endif

    assign Q  = w_qView;
    assign Qa = Ea ? w_aView : '0;
    assign Qb = Eb ? w_bView : '0;
    assign Z  = (w_qView == '0);
    assign CO = r_co;

    // Register file and carry flop: reset wins, otherwise only the WSEL register updates
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_co <= 1'b0;
        end else if (w_write) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (WSEL == AW'(i)) begin
                    r_regs[i] <= w_nextVal;
                end
            end
            r_co <= w_nextCo;
        end
    end

endmodule
